// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: Avalon-MM burst read master for self-test of the SDRAM path.
// Reads word_count words starting at base_address in row-bounded bursts (one outstanding),
// compares each beat to an incrementing pattern starting at pattern_seed, and reports the
// mismatch count, the byte address of the first mismatch and a sticky watchdog timeout.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  run request, honoured only while idle
//   base_address           first byte address (bit 0 ignored)
//   word_count             words to read (0 = finish without bus traffic)
//   pattern_seed           expected value of the first word
//   busy, done             run in progress / one-cycle end-of-run pulse
//   timeout                sticky watchdog flag, cleared by the next start
//   error_count            saturating mismatch count
//   first_err_addr         byte address of the first mismatching word
//   dbus_*                 Avalon-MM read master towards the SDRAM controller
module sdram_burst_reader #(
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_W   = 7,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned COL_W     = 9,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_address,
    input  logic [23:0]        word_count,
    input  logic [DATA_W-1:0]  pattern_seed,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [15:0]        error_count,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [ADDR_W-1:0]  dbus_address,
    output logic [BURST_W-1:0] dbus_burstcount,
    output logic [1:0]         dbus_byteenable,
    output logic               dbus_read,
    output logic               dbus_write,
    input  logic               dbus_waitrequest,
    input  logic [DATA_W-1:0]  dbus_readdata,
    input  logic               dbus_readdatavalid
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StData, StFin} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;     // start byte address of current burst
    logic [ADDR_W-1:0]   word_addr_q, word_addr_d;   // byte address of the next beat
    logic [23:0]         remaining_q, remaining_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic [BURST_W-1:0]  beats_left_q, beats_left_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;

    // Burst length: limited by MAX_BURST, the words still to read and the room left in the row.
    logic [COL_W-1:0]    col;
    logic [COL_W:0]      room;
    logic [BURST_W-1:0]  len;

    assign col  = cur_addr_q[COL_W:1];
    assign room = {1'b1, {COL_W{1'b0}}} - {1'b0, col};

    always_comb begin
        len = BURST_W'(MAX_BURST);
        if (remaining_q < 24'(MAX_BURST)) begin
            len = remaining_q[BURST_W-1:0];
        end
        if (room < (COL_W + 1)'(len)) begin
            len = room[BURST_W-1:0];
        end
    end

    logic wd_expired;
    assign wd_expired = (wd_q == WdW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        word_addr_d  = word_addr_q;
        remaining_d  = remaining_q;
        expected_d   = expected_q;
        beats_left_d = beats_left_q;
        wd_d         = wd_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timeout_d    = timeout_q;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_addr_d  = base_address & ~ADDR_W'(1);
                    word_addr_d = base_address & ~ADDR_W'(1);
                    remaining_d = word_count;
                    expected_d  = pattern_seed;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    timeout_d   = 1'b0;
                    busy_d      = 1'b1;
                    wd_d        = '0;
                    state_d     = (word_count == 24'd0) ? StFin : StReq;
                end
            end
            StReq: begin
                if (!dbus_waitrequest) begin
                    beats_left_d = len;
                    wd_d         = '0;
                    state_d      = StData;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StFin;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            StData: begin
                if (dbus_readdatavalid) begin
                    if (dbus_readdata != expected_q) begin
                        if (err_cnt_q == 16'd0) begin
                            first_err_d = word_addr_q;
                        end
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                    expected_d   = expected_q + DATA_W'(1);
                    word_addr_d  = word_addr_q + ADDR_W'(2);
                    remaining_d  = remaining_q - 24'd1;
                    beats_left_d = beats_left_q - BURST_W'(1);
                    wd_d         = '0;
                    if (beats_left_q == BURST_W'(1)) begin
                        if (remaining_q == 24'd1) begin
                            state_d = StFin;
                        end else begin
                            // Next burst starts right after the last word of this one.
                            cur_addr_d = word_addr_q + ADDR_W'(2);
                            state_d    = StReq;
                        end
                    end
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = StFin;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            word_addr_q  <= '0;
            remaining_q  <= '0;
            expected_q   <= '0;
            beats_left_q <= '0;
            wd_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            word_addr_q  <= word_addr_d;
            remaining_q  <= remaining_d;
            expected_q   <= expected_d;
            beats_left_q <= beats_left_d;
            wd_q         <= wd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
        end
    end

    // Request is decoded from state so reset drops it without waiting for a clock edge.
    assign dbus_read       = (state_q == StReq);
    assign dbus_address    = cur_addr_q;
    assign dbus_burstcount = (state_q == StReq) ? len : BURST_W'(1);
    assign dbus_byteenable = 2'b11;
    assign dbus_write      = 1'b0;

    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign error_count    = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Self-checking bench for sdram_burst_reader: an Avalon-MM slave model backed by a sparse
// memory, plus a reference model that derives the burst list and mismatch results from
// the run parameters and memory contents.
module tb_sdram_burst_reader;

    localparam int unsigned ADDR_W    = 25;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BURST_W   = 7;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned COL_W     = 9;
    localparam int unsigned TIMEOUT   = 1023;
    localparam int unsigned AMASK     = (1 << ADDR_W) - 1;

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  base_address;
    logic [23:0]        word_count;
    logic [DATA_W-1:0]  pattern_seed;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [15:0]        error_count;
    logic [ADDR_W-1:0]  first_err_addr;
    logic [ADDR_W-1:0]  dbus_address;
    logic [BURST_W-1:0] dbus_burstcount;
    logic [1:0]         dbus_byteenable;
    logic               dbus_read;
    logic               dbus_write;
    logic               dbus_waitrequest;
    logic [DATA_W-1:0]  dbus_readdata;
    logic               dbus_readdatavalid;

    sdram_burst_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_W   (BURST_W),
        .MAX_BURST (MAX_BURST),
        .COL_W     (COL_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .base_address       (base_address),
        .word_count         (word_count),
        .pattern_seed       (pattern_seed),
        .busy               (busy),
        .done               (done),
        .timeout            (timeout),
        .error_count        (error_count),
        .first_err_addr     (first_err_addr),
        .dbus_address       (dbus_address),
        .dbus_burstcount    (dbus_burstcount),
        .dbus_byteenable    (dbus_byteenable),
        .dbus_read          (dbus_read),
        .dbus_write         (dbus_write),
        .dbus_waitrequest   (dbus_waitrequest),
        .dbus_readdata      (dbus_readdata),
        .dbus_readdatavalid (dbus_readdatavalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sparse memory: word byte address -> data; unwritten words read as 16'hDEAD.
    logic [15:0] mem [int unsigned];

    function automatic logic [15:0] rd(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return 16'hDEAD;
    endfunction

    // Fill memory with the pattern a run expects, optionally corrupting random words.
    task automatic fill(input int unsigned base, input int unsigned count,
                        input logic [15:0] seed, input bit corrupt);
        logic [15:0] v;
        mem.delete();
        for (int unsigned i = 0; i < count; i++) begin
            v = seed + 16'(i);
            if (corrupt && $urandom_range(7) == 0) v = v ^ 16'(1 << $urandom_range(15));
            mem[((base & ~32'd1) + 2 * i) & AMASK] = v;
        end
    endtask

    // Slave model state
    int unsigned cmd_addr[$];
    int unsigned cmd_len[$];
    logic [15:0] pend[$];
    int          stall_left  = 0;
    bit          rand_wait   = 0;
    bit          rand_gap    = 0;
    bit          mute_data   = 0;
    bit          stray       = 0;
    int          read_cycles = 0;
    int          done_pulses = 0;
    longint      acc_cyc     = 0;
    bit          stalled     = 0;
    int unsigned s_addr, s_len;

    initial begin
        dbus_waitrequest   = 1'b0;
        dbus_readdatavalid = 1'b0;
        dbus_readdata      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("stall_read_held", dbus_read, 1);
                    check("stall_addr_stable", dbus_address, s_addr);
                    check("stall_len_stable", dbus_burstcount, s_len);
                end
                stalled = dbus_read && dbus_waitrequest;
                s_addr  = dbus_address;
                s_len   = dbus_burstcount;
                if (dbus_read) read_cycles++;
                if (done) done_pulses++;
                if (dbus_read && dbus_waitrequest && stall_left > 0) stall_left--;
                if (dbus_readdatavalid && !stray && pend.size() > 0) void'(pend.pop_front());
                if (dbus_read && !dbus_waitrequest) begin
                    check("one_outstanding", pend.size(), 0);
                    cmd_addr.push_back(dbus_address);
                    cmd_len.push_back(dbus_burstcount);
                    acc_cyc = cyc;
                    if (!mute_data) begin
                        for (int unsigned i = 0; i < dbus_burstcount; i++) begin
                            pend.push_back(rd((dbus_address + 2 * i) & AMASK));
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                dbus_waitrequest   = 1'b0;
                dbus_readdatavalid = 1'b0;
            end else if (stray) begin
                dbus_waitrequest   = 1'b0;
                dbus_readdatavalid = 1'b1;
                dbus_readdata      = 16'hBAD0;
            end else begin
                dbus_waitrequest = (stall_left > 0) || (rand_wait && $urandom_range(2) == 0);
                if (pend.size() > 0 && (!rand_gap || $urandom_range(3) != 0)) begin
                    dbus_readdatavalid = 1'b1;
                    dbus_readdata      = pend[0];
                end else begin
                    dbus_readdatavalid = 1'b0;
                end
            end
        end
    end

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_timeout"}, timeout, 0);
        check({pfx, "_errcnt"}, error_count, 0);
        check({pfx, "_firsterr"}, first_err_addr, 0);
        check({pfx, "_read"}, dbus_read, 0);
        check({pfx, "_addr"}, dbus_address, 0);
        check({pfx, "_burst"}, dbus_burstcount, 1);
        check({pfx, "_be"}, dbus_byteenable, 2'b11);
        check({pfx, "_write"}, dbus_write, 0);
    endtask

    longint done_cyc;

    // One complete run: reference model, start pulse, bounded wait for done, result checks.
    task automatic run(input int unsigned base, input int unsigned count, input logic [15:0] seed,
                       input bit expect_to, input bit poke_start, output int wait_n);
        int unsigned eb_addr[$];
        int unsigned eb_len[$];
        int unsigned a, rem, col, len, exp_err, exp_first, limit;
        bit got;

        a   = base & AMASK & ~32'd1;
        rem = count;
        while (rem > 0) begin
            col = (a >> 1) & ((1 << COL_W) - 1);
            len = MAX_BURST;
            if (rem < len) len = rem;
            if ((1 << COL_W) - col < len) len = (1 << COL_W) - col;
            eb_addr.push_back(a);
            eb_len.push_back(len);
            a   = (a + 2 * len) & AMASK;
            rem -= len;
        end
        exp_err   = 0;
        exp_first = 0;
        for (int unsigned i = 0; i < count; i++) begin
            a = ((base & ~32'd1) + 2 * i) & AMASK;
            if (rd(a) != seed + 16'(i)) begin
                exp_err++;
                if (exp_err == 1) exp_first = a;
            end
        end

        cmd_addr.delete();
        cmd_len.delete();
        done_pulses = 0;
        read_cycles = 0;
        @(posedge clk);
        #1;
        start        = 1'b1;
        base_address = ADDR_W'(base);
        word_count   = 24'(count);
        pattern_seed = seed;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);

        limit  = count * 16 + TIMEOUT + 200;
        got    = 0;
        wait_n = 0;
        for (int n = 1; n <= int'(limit); n++) begin
            @(negedge clk);
            start  = 1'b0;
            wait_n = n;
            if (done) begin
                got      = 1;
                done_cyc = cyc;
                break;
            end
            if (poke_start && n == 3) begin
                start        = 1'b1;
                base_address = ADDR_W'(32'h1234);
                word_count   = 24'd5;
            end
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("busy_at_done", busy, 0);
        check("read_at_done", dbus_read, 0);
        check("timeout_flag", timeout, expect_to);
        if (!expect_to) begin
            check("error_count", error_count, exp_err);
            check("first_err_addr", first_err_addr, exp_first);
            check("n_bursts", cmd_addr.size(), eb_addr.size());
            for (int i = 0; i < cmd_addr.size() && i < eb_addr.size(); i++) begin
                check($sformatf("burst%0d_addr", i), cmd_addr[i], eb_addr[i]);
                check($sformatf("burst%0d_len", i), cmd_len[i], eb_len[i]);
            end
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_pulses, 1);
        if (count == 0) begin
            check("zero_done_latency", wait_n, 2);
            check("zero_no_read", read_cycles, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int unsigned base, count;
        logic [15:0] seed;
        bit got;

        rst          = 1'b1;
        start        = 1'b0;
        base_address = '0;
        word_count   = '0;
        pattern_seed = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Linear read 0x1000+i from address 0: bursts 16, 16, 8.
        fill(0, 40, 16'h1000, 0);
        run(0, 40, 16'h1000, 0, 0, w);

        // Start six words before the end of a row: 6 + 6 split at the boundary.
        fill(32'h7F4, 12, 16'h55AA, 0);
        run(32'h7F4, 12, 16'h55AA, 0, 0, w);

        // Words 5 and 9 corrupted.
        fill(32'h100, 16, 16'h2000, 0);
        mem[32'h10A] = mem[32'h10A] ^ 16'h0001;
        mem[32'h112] = mem[32'h112] ^ 16'h8000;
        run(32'h100, 16, 16'h2000, 0, 0, w);
        check("corrupt_errcnt", error_count, 2);
        check("corrupt_first", first_err_addr, 32'h10A);

        // Beats while idle must not be compared.
        stray = 1;
        repeat (5) @(negedge clk);
        stray = 0;
        repeat (2) @(negedge clk);
        check("stray_errcnt", error_count, 2);
        check("stray_busy", busy, 0);

        // Seven stalled request cycles then acceptance.
        stall_left = 7;
        fill(32'h40, 4, 16'h3000, 0);
        run(32'h40, 4, 16'h3000, 0, 0, w);
        check("stall_read_cycles", read_cycles, 8);
        check("stall_one_cmd", cmd_addr.size(), 1);

        // Zero-length run.
        run(32'h200, 0, 16'h0, 0, 0, w);

        // Slave never answers: watchdog.
        mute_data = 1;
        fill(32'h300, 8, 16'h4000, 0);
        run(32'h300, 8, 16'h4000, 1, 0, w);
        mute_data = 0;
        check("to_one_cmd", cmd_addr.size(), 1);
        check("to_latency_ok",
              (done_cyc - acc_cyc >= TIMEOUT) && (done_cyc - acc_cyc <= TIMEOUT + 3), 1);

        // Odd base near the top of the address space: bit 0 dropped, wraps to 0.
        fill(AMASK - 8, 10, 16'hFFFC, 0);
        run(AMASK - 8, 10, 16'hFFFC, 0, 0, w);
        check("timeout_cleared", timeout, 0);

        // Randomized runs with stalls, data gaps, corruption and an ignored mid-run start.
        rand_wait = 1;
        rand_gap  = 1;
        for (int it = 0; it < 8; it++) begin
            base  = $urandom & AMASK;
            count = $urandom_range(60, 1);
            seed  = 16'($urandom);
            fill(base, count, seed, 1);
            run(base, count, seed, 0, count >= 20, w);
        end
        rand_wait = 0;
        rand_gap  = 0;

        // Asynchronous reset in the middle of a multi-burst run.
        fill(0, 40, 16'h1000, 0);
        cmd_addr.delete();
        @(posedge clk);
        #1;
        start        = 1'b1;
        base_address = '0;
        word_count   = 24'd40;
        pattern_seed = 16'h1000;
        @(posedge clk);
        #1;
        start = 1'b0;
        got   = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cmd_addr.size() >= 2) begin
                got = 1;
                break;
            end
        end
        check("midrst_reached", got, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        read_cycles = 0;
        repeat (10) @(negedge clk);
        check("post_rst_no_read", read_cycles, 0);
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
